// File: rtl/mem_lsu_stage.sv
// rtl/mem_lsu_stage.sv - load/store stage between EX and WB with single-outstanding data bus
module mem_lsu_stage #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_result,
   input  logic [31:0]       i_data_store,
   input  logic [31:0]       i_pc,
   input  logic [6:0]        i_opcode,
   input  logic [2:0]        i_func3,
   output logic              o_stall,
   output logic              o_valid,
   output logic [31:0]       o_wb_data,
   output logic [6:0]        o_opcode,
   output logic              o_misaligned,
   output logic              o_bus_err,
   output logic              o_stb,
   output logic              o_wr_en,
   output logic [3:0]        o_sel,
   output logic [ADDR_W-1:0] o_addr,
   output logic [31:0]       o_wr_data,
   input  logic              i_ack,
   input  logic [31:0]       i_read_data
);
   localparam int CW = (TO_W > 0) ? TO_W : 1;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_J  = 7'b1101111;
   localparam logic [6:0] OP_JR = 7'b1100111;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    f3_q;
   logic [1:0]    lane_q;
   logic          load_q;

   logic          is_store, is_mem, misal, timeout_hit;
   logic [1:0]    lane;
   logic [3:0]    sel_c;
   logic [31:0]   wdata_c, shifted, load_val;

   assign lane    = i_result[1:0];
   assign o_stall = (state == ACCESS);

   always_comb begin
      is_store = (i_opcode == OP_S);
      is_mem   = is_store || (i_opcode == OP_LD);
      misal    = 1'b0;
      sel_c    = 4'b1111;
      wdata_c  = i_data_store;
      case (i_func3[1:0])
         2'b00: begin
            sel_c   = 4'b0001 << lane;
            wdata_c = {4{i_data_store[7:0]}};
         end
         2'b01: begin
            misal   = lane[0];
            sel_c   = 4'b0011 << lane;
            wdata_c = {2{i_data_store[15:0]}};
         end
         default: misal = (lane != 2'b00);
      endcase
   end

   // Bring the addressed lane down to bit 0 before extension.
   always_comb begin
      shifted = i_read_data >> {lane_q, 3'b000};
      case (f3_q)
         3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_val = {24'd0, shifted[7:0]};
         3'b101:  load_val = {16'd0, shifted[15:0]};
         default: load_val = shifted;
      endcase
   end

   assign timeout_hit = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         f3_q         <= '0;
         lane_q       <= '0;
         load_q       <= 1'b0;
         o_valid      <= 1'b0;
         o_wb_data    <= '0;
         o_opcode     <= '0;
         o_misaligned <= 1'b0;
         o_bus_err    <= 1'b0;
         o_stb        <= 1'b0;
         o_wr_en      <= 1'b0;
         o_sel        <= '0;
         o_addr       <= '0;
         o_wr_data    <= '0;
      end else begin
         o_valid      <= 1'b0;
         o_misaligned <= 1'b0;
         o_bus_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (i_valid) begin
                  o_opcode <= i_opcode;
                  if (is_mem && misal) begin
                     o_valid      <= 1'b1;
                     o_misaligned <= 1'b1;
                     o_wb_data    <= '0;
                  end else if (is_mem) begin
                     o_stb     <= 1'b1;
                     o_addr    <= i_result;
                     o_sel     <= sel_c;
                     o_wr_en   <= is_store;
                     o_wr_data <= is_store ? wdata_c : 32'd0;
                     f3_q      <= i_func3;
                     lane_q    <= lane;
                     load_q    <= ~is_store;
                     cnt       <= '0;
                     state     <= ACCESS;
                  end else if (i_opcode == OP_J || i_opcode == OP_JR) begin
                     o_valid   <= 1'b1;
                     o_wb_data <= i_pc + 32'd4;
                  end else begin
                     o_valid   <= 1'b1;
                     o_wb_data <= 32'(i_result);
                  end
               end
            end
            ACCESS: begin
               // An ack on the timeout edge still counts as a normal completion.
               if (i_ack || timeout_hit) begin
                  o_stb     <= 1'b0;
                  o_addr    <= '0;
                  o_sel     <= '0;
                  o_wr_en   <= 1'b0;
                  o_wr_data <= '0;
                  o_valid   <= 1'b1;
                  o_bus_err <= ~i_ack;
                  o_wb_data <= (i_ack && load_q) ? load_val : 32'd0;
                  cnt       <= '0;
                  state     <= IDLE;
               end else if (TIMEOUT > 0) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_lsu_stage.sv
// tb/tb_mem_lsu_stage.sv - scoreboard bench for mem_lsu_stage
module tb_mem_lsu_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_valid;
   logic [31:0] i_result, i_data_store, i_pc;
   logic [6:0]  i_opcode;
   logic [2:0]  i_func3;
   logic        o_stall, o_valid, o_misaligned, o_bus_err, o_stb, o_wr_en;
   logic [31:0] o_wb_data, o_wr_data, o_addr;
   logic [6:0]  o_opcode;
   logic [3:0]  o_sel;
   logic        i_ack;
   logic [31:0] i_read_data;

   mem_lsu_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_result(i_result),
      .i_data_store(i_data_store), .i_pc(i_pc), .i_opcode(i_opcode), .i_func3(i_func3),
      .o_stall(o_stall), .o_valid(o_valid), .o_wb_data(o_wb_data), .o_opcode(o_opcode),
      .o_misaligned(o_misaligned), .o_bus_err(o_bus_err), .o_stb(o_stb), .o_wr_en(o_wr_en),
      .o_sel(o_sel), .o_addr(o_addr), .o_wr_data(o_wr_data), .i_ack(i_ack),
      .i_read_data(i_read_data)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, JAL = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111, ALU = 7'b0110011, ALUI = 7'b0010011;

   typedef struct {
      logic [31:0] wb;
      logic [6:0]  op;
      logic        mis;
      logic        err;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  sel;
      logic        wr_en;
      logic [31:0] wr_data;
      logic [31:0] rdata;
      int          ack_after;
      int          exp_len;
   } bus_t;

   exp_t sb_q[$];
   bus_t bus_q[$];
   int   checks = 0;
   int   failures = 0;
   int   valid_seen = 0;
   bit   active = 0;
   int   len = 0;
   bus_t cur;

   // Writeback monitor.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if ((o_misaligned || o_bus_err) && !o_valid) begin
            failures++;
            $display("FAIL flag_without_valid: mis=%0b err=%0b valid=0", o_misaligned, o_bus_err);
         end
         if (o_valid) begin
            exp_t e;
            valid_seen++;
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_valid: got wb=%h op=%b, expected none", o_wb_data, o_opcode);
            end else begin
               e = sb_q.pop_front();
               if (o_wb_data !== e.wb || o_opcode !== e.op || o_misaligned !== e.mis || o_bus_err !== e.err) begin
                  failures++;
                  $display("FAIL wb_result: got wb=%h op=%b mis=%b err=%b, expected wb=%h op=%b mis=%b err=%b",
                           o_wb_data, o_opcode, o_misaligned, o_bus_err, e.wb, e.op, e.mis, e.err);
               end
            end
         end
      end
   end

   // Bus responder and request checker.
   always @(negedge clk) begin
      if (!rst_n) begin
         active = 0;
         i_ack  = 1'b0;
      end else if (!active) begin
         if (o_stb) begin
            checks++;
            if (bus_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_stb: addr=%h sel=%b, expected no bus cycle", o_addr, o_sel);
            end else begin
               cur = bus_q.pop_front();
               if (o_addr !== cur.addr || o_sel !== cur.sel || o_wr_en !== cur.wr_en ||
                   (cur.wr_en && o_wr_data !== cur.wr_data)) begin
                  failures++;
                  $display("FAIL bus_request: got addr=%h sel=%b we=%b wd=%h, expected addr=%h sel=%b we=%b wd=%h",
                           o_addr, o_sel, o_wr_en, o_wr_data, cur.addr, cur.sel, cur.wr_en, cur.wr_data);
               end
               active = 1;
               len = 1;
               i_read_data = cur.rdata;
               i_ack = (cur.ack_after == 1);
            end
         end
      end else if (o_stb) begin
         len++;
         i_ack = (len == cur.ack_after);
      end else begin
         checks++;
         if (len != cur.exp_len) begin
            failures++;
            $display("FAIL stb_length: got %0d cycles, expected %0d", len, cur.exp_len);
         end
         active = 0;
         i_ack = 1'b0;
      end
   end

   task automatic push_bus(input logic [31:0] addr, input logic [3:0] sel, input logic we,
                           input logic [31:0] wd, input logic [31:0] rd, input int ack_after,
                           input int exp_len);
      bus_t b;
      b.addr = addr; b.sel = sel; b.wr_en = we; b.wr_data = wd;
      b.rdata = rd; b.ack_after = ack_after; b.exp_len = exp_len;
      bus_q.push_back(b);
   endtask

   // Caller is just after a negedge; holds the instruction until accepted.
   task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                       input logic [31:0] sd, input logic [31:0] pc, input bit expect_wb,
                       input logic [31:0] wb, input logic mis, input logic err);
      int n = 0;
      exp_t e;
      while (o_stall && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         failures++;
         $display("FAIL stall_timeout: o_stall=1 after 50 cycles, expected 0");
      end
      i_valid = 1'b1; i_opcode = op; i_func3 = f3;
      i_result = res; i_data_store = sd; i_pc = pc;
      if (expect_wb) begin
         e.wb = wb; e.op = op; e.mis = mis; e.err = err;
         sb_q.push_back(e);
      end
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   initial begin
      int n;
      int vs;
      rst_n = 1'b0; i_valid = 1'b0; i_result = '0; i_data_store = '0; i_pc = '0;
      i_opcode = '0; i_func3 = '0; i_ack = 1'b0; i_read_data = '0;
      repeat (2) @(negedge clk);
      check_val("reset_outputs", {o_valid, o_stall, o_stb, o_wr_en, o_misaligned, o_bus_err, o_sel}, 32'd0);
      check_val("reset_wb_data", o_wb_data, 32'd0);
      check_val("reset_addr", o_addr, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send(ALU,  3'b000, 32'h0000_1234, 0, 0, 1, 32'h0000_1234, 0, 0);
      send(ALUI, 3'b010, 32'hDEAD_BEEF, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
      send(JAL,  3'b000, 32'h0, 0, 32'hFFFF_FFFC, 1, 32'h0000_0000, 0, 0);
      send(JALR, 3'b000, 32'h0, 0, 32'h0000_0100, 1, 32'h0000_0104, 0, 0);

      push_bus(32'h103, 4'b1000, 0, 0, 32'h80FF_0000, 3, 3);
      send(LD, 3'b000, 32'h103, 0, 0, 1, 32'hFFFF_FF80, 0, 0);
      push_bus(32'h103, 4'b1000, 0, 0, 32'h80FF_0000, 3, 3);
      send(LD, 3'b100, 32'h103, 0, 0, 1, 32'h0000_0080, 0, 0);
      push_bus(32'h102, 4'b1100, 0, 0, 32'h8001_0000, 1, 1);
      send(LD, 3'b001, 32'h102, 0, 0, 1, 32'hFFFF_8001, 0, 0);
      push_bus(32'h102, 4'b1100, 0, 0, 32'h8001_0000, 2, 2);
      send(LD, 3'b101, 32'h102, 0, 0, 1, 32'h0000_8001, 0, 0);
      push_bus(32'h200, 4'b1111, 0, 0, 32'h1234_5678, 2, 2);
      send(LD, 3'b010, 32'h200, 0, 0, 1, 32'h1234_5678, 0, 0);
      push_bus(32'h101, 4'b0010, 0, 0, 32'h0000_7F00, 1, 1);
      send(LD, 3'b000, 32'h101, 0, 0, 1, 32'h0000_007F, 0, 0);

      push_bus(32'h202, 4'b1100, 1, 32'hBEEF_BEEF, 0, 2, 2);
      send(ST, 3'b001, 32'h202, 32'hAAAA_BEEF, 0, 1, 32'h0, 0, 0);
      push_bus(32'h001, 4'b0010, 1, 32'hA5A5_A5A5, 0, 1, 1);
      send(ST, 3'b000, 32'h001, 32'h1234_56A5, 0, 1, 32'h0, 0, 0);
      push_bus(32'h300, 4'b1111, 1, 32'hCAFE_F00D, 0, 3, 3);
      send(ST, 3'b010, 32'h300, 32'hCAFE_F00D, 0, 1, 32'h0, 0, 0);

      send(LD, 3'b010, 32'h101, 0, 0, 1, 32'h0, 1, 0);
      send(LD, 3'b001, 32'h103, 0, 0, 1, 32'h0, 1, 0);
      send(ST, 3'b010, 32'h302, 32'h1111_1111, 0, 1, 32'h0, 1, 0);
      send(ST, 3'b001, 32'h201, 32'h2222_2222, 0, 1, 32'h0, 1, 0);

      push_bus(32'h400, 4'b1111, 0, 0, 32'h55AA_55AA, 0, 4);
      send(LD, 3'b010, 32'h400, 0, 0, 1, 32'h0, 0, 1);
      push_bus(32'h404, 4'b1111, 0, 0, 32'h55AA_55AA, 4, 4);
      send(LD, 3'b010, 32'h404, 0, 0, 1, 32'h55AA_55AA, 0, 0);

      n = 0;
      while ((sb_q.size() != 0 || active || o_stall) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val("drain_scoreboard", sb_q.size(), 0);
      check_val("drain_bus_queue", bus_q.size(), 0);

      push_bus(32'h500, 4'b1111, 0, 0, 32'h0, 0, 0);
      send(LD, 3'b010, 32'h500, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_val("stb_before_reset", o_stb, 1);
      rst_n = 1'b0;
      #1;
      check_val("stb_in_reset", {o_stb, o_stall, o_valid}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      vs = valid_seen;
      repeat (6) @(negedge clk);
      check_val("no_valid_after_reset", valid_seen - vs, 0);
      check_val("no_stb_after_reset", o_stb, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
